mod3_check_serializer: RTL and testbench
========================================

Name: mod3_check_serializer

Overview:
Transmit-side partner of the serial multiple-of-three detector. Accepts a DATA_W-bit parallel word through a valid/ready handshake. Shifts the word out MSB-first, one bit per transferred beat. Then appends 2 check bits so that the whole (DATA_W+2)-bit serial value is an exact multiple of 3, so a downstream mod-3 detector reports "divisible" on the last beat of every frame.

Parameters:
DATA_W, 8, payload width in bits (legal range 2..32)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high; clock clk
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word; high only in IDLE
in_data  input  DATA_W  payload word, captured when in_valid & in_ready
tx_ready  input  1  downstream accepts current beat
tx_valid  output  1  tx_bit holds a valid beat
tx_bit  output  1  serial bit; payload MSB-first, then check bit 1, then check bit 0
tx_check  output  1  current beat is a check bit
tx_last  output  1  current beat is the final (check bit 0) beat of the frame
busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset values: state IDLE, tx_valid=0, tx_bit=0, tx_check=0, tx_last=0, busy=0, remainder r=0, bit counter=0. in_ready=1 the cycle after reset.
- All outputs except in_ready are registered. in_ready = (state==IDLE), decoded directly from the state register.
- States: IDLE, DATA, CHK1, CHK0.
- IDLE:
  - On in_valid=1, load in_data into the shift register, clear r, set counter=DATA_W-1, go to DATA.
  - tx_valid rises the next cycle with tx_bit = in_data[DATA_W-1].
  - Latency: accept at edge k, first beat valid from cycle k+1.
- Beat transfer = tx_valid & tx_ready. While tx_valid=1 and tx_ready=0, tx_bit, tx_check and tx_last hold stable and no state advances.
- DATA:
  - On each transfer, update r' = (2r + tx_bit) mod 3, using 2-bit encoding 0/1/2; value 3 is never reached.
  - Shift left and decrement the counter.
  - On the transfer with counter==0, go to CHK1.
- Check value c = (3 - r_final) mod 3, where r_final includes the last payload bit.
  - Derivation: frame value = payload*4 + c, and 4 ≡ 1 mod 3.
  - Mapping: r=0 gives c=00, r=1 gives c=10, r=2 gives c=01.
- CHK1: tx_bit=c[1], tx_check=1, tx_last=0; go to CHK0 on transfer.
- CHK0: tx_bit=c[0], tx_check=1, tx_last=1; go to IDLE on transfer. tx_valid drops the next cycle.
- No back-to-back frames: at least one IDLE cycle (tx_valid=0) separates frames. in_valid is ignored while busy, and no word is captured.
- Frame length with tx_ready tied high: exactly DATA_W+2 consecutive tx_valid cycles.
- Reset mid-frame aborts the frame. The next cycle shows IDLE/reset values, and the partial frame is not completed.
- reset and in_valid asserted together: reset wins and nothing is captured.
- in_data changing after capture has no effect on the frame in flight.

Decomposition:
- Shared package mod3_pkg holds:
  - state enum {IDLE, DATA, CHK1, CHK0};
  - localparam CHK_W=2;
  - remainder encoding constants R0=2'd0, R1=2'd1, R2=2'd2;
  - function mod3_step(r, bit) returning (2r+bit) mod 3;
  - function mod3_check(r) returning the check bits.
- The detector and this block both use mod3_step.
- One natural sub-module: mod3_accum. It is the registered remainder with clear/enable inputs and a 2-bit output, reusable by the receive side.

Test Plan:
- Reset then in_data=8'h01, tx_ready=1 -> tx_bit sequence 0000000110 (value 6); tx_check=1 on beats 9-10 only, tx_last=1 on beat 10 only, in_ready=0 for all 10 beats.
- in_data=8'h02 -> 0000001001 (value 9), check bits 01. in_data=8'h05 -> 0000010101 (value 21), check bits 01.
- in_data=8'hFF and 8'h00 -> check bits 00 for both; frame values 1020 and 0.
- tx_ready toggled pseudo-randomly during frame 8'hA7 -> the bit sequence equals the unstalled sequence 1010011101; tx_bit is stable across every stall.
- in_valid held high with changing in_data throughout a frame -> only the word at the IDLE edge is sent; one tx_valid=0 bubble between frames.
- reset asserted on beat 5 of a frame -> tx_valid=0, busy=0, in_ready=1 the next cycle; the following frame 8'h03 sends 0000001100 correctly.
- Scoreboard on every frame: a reference mod-3 detector sees r==0 at tx_last.

Source files
------------

// File: rtl/mod3_pkg.sv
// Shared definitions for the mod-3 check serializer and its receive-side partner.
//   state_t     : serializer frame states
//   CHK_W       : number of appended check bits
//   R0/R1/R2    : remainder encodings (value 3 never occurs)
//   mod3_step   : (2r + b) mod 3, one MSB-first bit step of a running remainder
//   mod3_check  : check bits c = (3 - r) mod 3 that make payload*4 + c divisible by 3
package mod3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CHK1 = 2'd2,
        CHK0 = 2'd3
    } state_t;

    localparam int CHK_W = 2;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;

    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] res;
        case (r)
            R0:      res = b ? R1 : R0;
            R1:      res = b ? R0 : R2;
            R2:      res = b ? R2 : R1;
            default: res = R0;
        endcase
        return res;
    endfunction

    // 4 = 1 mod 3, so the check value only has to cancel the payload remainder.
    function automatic logic [CHK_W-1:0] mod3_check(input logic [1:0] r);
        logic [CHK_W-1:0] c;
        case (r)
            R1:      c = 2'b10;
            R2:      c = 2'b01;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mod3_accum.sv
// Registered running mod-3 remainder of an MSB-first bit stream.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force remainder to 0 (start of frame)
//   enable     : fold data_bit into the remainder
//   data_bit   : incoming serial bit
//   r          : current remainder (0..2)
module mod3_accum
    import mod3_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [1:0] r
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r <= R0;
        end else if (enable) begin
            r <= mod3_step(r, data_bit);
        end
    end

endmodule

// File: rtl/mod3_check_serializer.sv
// Serializes a DATA_W-bit word MSB-first and appends 2 check bits so the whole
// frame value is a multiple of 3.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : word handshake; in_ready high only in IDLE
//   in_data             : payload word
//   tx_valid/tx_ready   : per-beat handshake
//   tx_bit              : serial bit (payload MSB-first, then check bit 1, check bit 0)
//   tx_check, tx_last   : beat is a check bit / final beat of frame
//   busy                : frame in progress
module mod3_check_serializer
    import mod3_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic              tx_bit,
    output logic              tx_check,
    output logic              tx_last,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state, state_nx;
    // The current payload bit lives in tx_bit, so only the remaining bits are held here.
    logic [DATA_W-2:0] rest, rest_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              tx_valid_nx, tx_bit_nx, tx_check_nx, tx_last_nx, busy_nx;
    logic              acc_clear, acc_en;
    logic [1:0]        r;
    logic [CHK_W-1:0]  chk_final, chk_held;
    logic              xfer;

    assign xfer      = tx_valid & tx_ready;
    assign in_ready  = (state == IDLE);
    // On the last payload transfer the remainder register has not yet absorbed
    // tx_bit, so fold it in here; afterwards the register holds r_final.
    assign chk_final = mod3_check(mod3_step(r, tx_bit));
    assign chk_held  = mod3_check(r);

    mod3_accum u_accum (
        .clk      (clk),
        .reset    (reset),
        .clear    (acc_clear),
        .enable   (acc_en),
        .data_bit (tx_bit),
        .r        (r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rest     <= '0;
            cnt      <= '0;
            tx_valid <= 1'b0;
            tx_bit   <= 1'b0;
            tx_check <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            rest     <= rest_nx;
            cnt      <= cnt_nx;
            tx_valid <= tx_valid_nx;
            tx_bit   <= tx_bit_nx;
            tx_check <= tx_check_nx;
            tx_last  <= tx_last_nx;
            busy     <= busy_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        rest_nx     = rest;
        cnt_nx      = cnt;
        tx_valid_nx = tx_valid;
        tx_bit_nx   = tx_bit;
        tx_check_nx = tx_check;
        tx_last_nx  = tx_last;
        busy_nx     = busy;
        acc_clear   = 1'b0;
        acc_en      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx    = DATA;
                    rest_nx     = in_data[DATA_W-2:0];
                    cnt_nx      = CNT_W'(DATA_W - 1);
                    tx_valid_nx = 1'b1;
                    tx_bit_nx   = in_data[DATA_W-1];
                    tx_check_nx = 1'b0;
                    tx_last_nx  = 1'b0;
                    busy_nx     = 1'b1;
                    acc_clear   = 1'b1;
                end
            end
            DATA: begin
                if (xfer) begin
                    acc_en  = 1'b1;
                    rest_nx = rest << 1;
                    cnt_nx  = cnt - 1'b1;
                    if (cnt == '0) begin
                        state_nx    = CHK1;
                        tx_bit_nx   = chk_final[1];
                        tx_check_nx = 1'b1;
                    end else begin
                        tx_bit_nx = rest[DATA_W-2];
                    end
                end
            end
            CHK1: begin
                if (xfer) begin
                    state_nx   = CHK0;
                    tx_bit_nx  = chk_held[0];
                    tx_last_nx = 1'b1;
                end
            end
            CHK0: begin
                if (xfer) begin
                    state_nx    = IDLE;
                    tx_valid_nx = 1'b0;
                    tx_bit_nx   = 1'b0;
                    tx_check_nx = 1'b0;
                    tx_last_nx  = 1'b0;
                    busy_nx     = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mod3_check_serializer.sv
// Self-checking bench for mod3_check_serializer (DATA_W = 8).
module tb_mod3_check_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         tx_ready;
    logic         tx_valid;
    logic         tx_bit;
    logic         tx_check;
    logic         tx_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod3_check_serializer #(.DATA_W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_bit   (tx_bit),
        .tx_check (tx_check),
        .tx_last  (tx_last),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole frame as a number: payload*4 + smallest c making it divisible by 3.
    function automatic logic [W+1:0] frame_of(input logic [W-1:0] d);
        int c;
        logic [W+1:0] v;
        c = (3 - (int'(d) % 3)) % 3;
        v = {d, 2'b00};
        v[1:0] = c[1:0];
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the last beat.
    task automatic run_frame(input logic [W-1:0] d, input bit stall, input bit hold);
        logic [W+1:0] exp_v;
        logic [W+1:0] got_v;
        int idx, budget, r;
        bit prev_stall;
        logic pb, pc, pl;
        exp_v = frame_of(d);
        got_v = '0;
        idx = 0;
        budget = 0;
        r = 0;
        prev_stall = 0;
        pb = 0; pc = 0; pl = 0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_tx_valid", tx_valid, 0);
        in_valid = 1'b1;
        in_data  = d;
        tx_ready = 1'b1;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        while (idx < W + 2 && budget < 300) begin
            budget++;
            in_data = W'($urandom);
            chk("beat_valid", tx_valid, 1);
            chk("beat_in_ready", in_ready, 0);
            chk("beat_busy", busy, 1);
            if (prev_stall) begin
                chk("stall_bit", tx_bit, pb);
                chk("stall_check", tx_check, pc);
                chk("stall_last", tx_last, pl);
            end
            chk("bit", tx_bit, exp_v[W+1-idx]);
            chk("check_flag", tx_check, (idx >= W) ? 1 : 0);
            chk("last_flag", tx_last, (idx == W + 1) ? 1 : 0);
            tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_ready && tx_valid) begin
                got_v = {got_v[W:0], tx_bit};
                r = (2 * r + int'(tx_bit)) % 3;
                if (tx_last) chk("detector_r_at_last", r, 0);
                idx++;
                prev_stall = 0;
            end else begin
                prev_stall = 1;
                pb = tx_bit;
                pc = tx_check;
                pl = tx_last;
            end
            @(negedge clk);
        end
        if (idx < W + 2) chk("frame_timeout", idx, W + 2);
        chk("frame_value", got_v, exp_v);
        chk("end_tx_valid", tx_valid, 0);
        chk("end_in_ready", in_ready, 1);
        tx_ready = 1'b1;
    endtask

    task automatic reset_mid(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tx_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_valid_before_reset", tx_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_tx_bit", tx_bit, 0);
        chk("abort_tx_check", tx_check, 0);
        chk("abort_tx_last", tx_last, 0);
        @(negedge clk);
        chk("abort_stays_idle", tx_valid, 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_bit", tx_bit, 0);
        chk("rst_tx_check", tx_check, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("no_capture_busy", busy, 0);
        chk("no_capture_valid", tx_valid, 0);

        run_frame(8'h01, 0, 0);
        run_frame(8'h02, 0, 0);
        run_frame(8'h05, 0, 0);
        run_frame(8'hFF, 0, 0);
        run_frame(8'h00, 0, 0);
        run_frame(8'hA7, 1, 0);

        run_frame(8'h3C, 0, 1);
        run_frame(8'hC3, 0, 1);
        run_frame(8'h5A, 1, 0);

        reset_mid(8'h96);
        run_frame(8'h03, 0, 0);

        for (int i = 0; i < 30; i++) begin
            run_frame(W'($urandom), ($urandom_range(0, 1) == 1), 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
